dmem_responder: RTL and testbench

Data-memory responder for the RV32I core: the slave end of the `dmem_*` / `funct3` load/store interface that the processor's execute stage drives. It decodes the address, sizes each access by `funct3` with byte-lane writes and sign or zero extension on loads, and holds a word-organised data RAM. It also provides a small memory-mapped peripheral window: PWM duty registers for the LED and RGB outputs, and free-running micro- and millisecond counters.

---
 rtl/dmem_if.sv | 19 +
 rtl/dmem_responder.sv | 176 +++++++++++++++++
 tb/tb_dmem_responder.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_if.sv
// Load/store bus between the RV32I execute stage (master) and the data-memory responder (slave).
interface dmem_if;
  logic [2:0]  funct3;
  logic        dmem_wren;
  logic [31:0] dmem_address;
  logic [31:0] dmem_data_in;
  logic [31:0] dmem_data_out;
  logic        misaligned;

  modport master (
    output funct3, dmem_wren, dmem_address, dmem_data_in,
    input  dmem_data_out, misaligned
  );

  modport slave (
    input  funct3, dmem_wren, dmem_address, dmem_data_in,
    output dmem_data_out, misaligned
  );
endinterface

// File: rtl/dmem_responder.sv
// Data RAM plus LED/RGB PWM duty registers and micro/millisecond counters behind the
// RV32I load/store bus, with funct3 sizing, byte-lane writes and load extension.
module dmem_responder #(
  parameter int          DMEM_WORDS = 2048,
  parameter logic [31:0] DMEM_BASE  = 32'h0000_2000,
  parameter int          CLK_HZ     = 12000000,
  parameter              INIT_FILE  = ""
) (
  input  logic   clk,
  input  logic   reset,
  dmem_if.slave  bus,
  output logic   led,
  output logic   red,
  output logic   green,
  output logic   blue
);

  localparam int          AW          = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;
  localparam int          US_TICKS    = (CLK_HZ / 1000000 < 1) ? 1 : CLK_HZ / 1000000;
  localparam int          PW          = (US_TICKS > 1) ? $clog2(US_TICKS) : 1;
  localparam logic [30:0] RAM_WORDS_L = 31'(DMEM_WORDS);

  logic [31:0]   r_ram [DMEM_WORDS];
  logic [31:0]   r_ledctl;
  logic [31:0]   r_dataOut;
  logic          r_misaligned;
  logic [7:0]    r_pwmCnt;
  logic [PW-1:0] r_prescale;
  logic [9:0]    r_usInMs;
  logic [31:0]   r_micros;
  logic [31:0]   r_millis;

  logic [32:0]   w_offset;
  logic          w_inRam;
  logic [AW-1:0] w_wordIdx;
  logic          w_isLedctl;
  logic          w_isMillis;
  logic          w_isMicros;
  logic          w_loadOk;
  logic          w_storeOk;
  logic          w_accessOk;
  logic          w_misaligned;
  logic          w_doStore;
  logic [31:0]   w_regionWord;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [31:0]   w_loadVal;
  logic [3:0]    w_byteEn;
  logic [31:0]   w_wrData;

  // A borrow out of the subtraction means the address lies below the RAM base.
  assign w_offset   = {1'b0, bus.dmem_address} - {1'b0, DMEM_BASE};
  assign w_inRam    = !w_offset[32] && ({1'b0, w_offset[31:2]} < RAM_WORDS_L);
  assign w_wordIdx  = w_offset[AW+1:2];
  assign w_isLedctl = bus.dmem_address[31:2] == 30'h3FFF_FFFF;
  assign w_isMillis = bus.dmem_address[31:2] == 30'h3FFF_FFFE;
  assign w_isMicros = bus.dmem_address[31:2] == 30'h3FFF_FFFD;

  assign w_loadOk     = (bus.funct3 != 3'b011) && (bus.funct3 != 3'b110) && (bus.funct3 != 3'b111);
  assign w_storeOk    = !bus.funct3[2] && (bus.funct3[1:0] != 2'b11);
  assign w_accessOk   = bus.dmem_wren ? w_storeOk : w_loadOk;
  assign w_misaligned = w_accessOk &&
                        (((bus.funct3[1:0] == 2'b01) && bus.dmem_address[0]) ||
                         ((bus.funct3[1:0] == 2'b10) && (bus.dmem_address[1:0] != 2'b00)));
  assign w_doStore    = !reset && bus.dmem_wren && w_storeOk && !w_misaligned;

  always_comb begin
    w_regionWord = 32'h0;
    if (w_inRam)         w_regionWord = r_ram[w_wordIdx];
    else if (w_isLedctl) w_regionWord = r_ledctl;
    else if (w_isMillis) w_regionWord = r_millis;
    else if (w_isMicros) w_regionWord = r_micros;
  end

  always_comb begin
    w_byte = w_regionWord[7:0];
    case (bus.dmem_address[1:0])
      2'd1:    w_byte = w_regionWord[15:8];
      2'd2:    w_byte = w_regionWord[23:16];
      2'd3:    w_byte = w_regionWord[31:24];
      default: w_byte = w_regionWord[7:0];
    endcase
    w_half    = bus.dmem_address[1] ? w_regionWord[31:16] : w_regionWord[15:0];
    w_loadVal = 32'h0;
    if (w_loadOk && !w_misaligned) begin
      case (bus.funct3)
        3'b000:  w_loadVal = {{24{w_byte[7]}}, w_byte};
        3'b001:  w_loadVal = {{16{w_half[15]}}, w_half};
        3'b010:  w_loadVal = w_regionWord;
        3'b100:  w_loadVal = {24'h0, w_byte};
        3'b101:  w_loadVal = {16'h0, w_half};
        default: w_loadVal = 32'h0;
      endcase
    end
  end

  // Store data is replicated across lanes so the byte-enable alone picks the target.
  always_comb begin
    w_byteEn = 4'b0000;
    w_wrData = bus.dmem_data_in;
    case (bus.funct3[1:0])
      2'b00: begin
        w_byteEn = 4'b0001 << bus.dmem_address[1:0];
        w_wrData = {4{bus.dmem_data_in[7:0]}};
      end
      2'b01: begin
        w_byteEn = bus.dmem_address[1] ? 4'b1100 : 4'b0011;
        w_wrData = {2{bus.dmem_data_in[15:0]}};
      end
      2'b10:   w_byteEn = 4'b1111;
      default: w_byteEn = 4'b0000;
    endcase
  end

  always @(posedge clk) begin
    if (w_doStore && w_inRam) begin
      for (int i = 0; i < 4; i++) begin
        if (w_byteEn[i]) r_ram[w_wordIdx][8*i +: 8] <= w_wrData[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ledctl <= 32'h0;
    end else if (w_doStore && w_isLedctl) begin
      for (int i = 0; i < 4; i++) begin
        if (w_byteEn[i]) r_ledctl[8*i +: 8] <= w_wrData[8*i +: 8];
      end
    end
  end

  // The load result only moves on load cycles; stores leave the last value in place.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dataOut    <= 32'h0;
      r_misaligned <= 1'b0;
    end else begin
      r_misaligned <= w_misaligned;
      if (!bus.dmem_wren) r_dataOut <= w_loadVal;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pwmCnt   <= 8'h0;
      r_prescale <= '0;
      r_usInMs   <= 10'd0;
      r_micros   <= 32'h0;
      r_millis   <= 32'h0;
    end else begin
      r_pwmCnt <= r_pwmCnt + 8'd1;
      if (r_prescale == PW'(US_TICKS - 1)) begin
        r_prescale <= '0;
        r_micros   <= r_micros + 32'd1;
        if (r_usInMs == 10'd999) begin
          r_usInMs <= 10'd0;
          r_millis <= r_millis + 32'd1;
        end else begin
          r_usInMs <= r_usInMs + 10'd1;
        end
      end else begin
        r_prescale <= r_prescale + PW'(1);
      end
    end
  end

  assign bus.dmem_data_out = r_dataOut;
  assign bus.misaligned    = r_misaligned;

  assign led   = r_pwmCnt < r_ledctl[7:0];
  assign red   = r_pwmCnt < r_ledctl[15:8];
  assign green = r_pwmCnt < r_ledctl[23:16];
  assign blue  = r_pwmCnt < r_ledctl[31:24];

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: byte-level reference model checked every cycle, directed
// scenarios with literal expectations, then a randomized access stream.
module tb_dmem_responder;

  localparam logic [31:0] BASE         = 32'h0000_2000;
  localparam int          WORDS        = 2048;
  localparam int          CLK_HZ       = 4_000_000;
  localparam int          TICKS_PER_US = CLK_HZ / 1_000_000;
  localparam logic [31:0] LEDCTL       = 32'hFFFF_FFFC;
  localparam logic [31:0] MILLIS       = 32'hFFFF_FFF8;
  localparam logic [31:0] MICROS       = 32'hFFFF_FFF4;

  logic clk = 1'b0;
  logic reset;
  logic led, red, green, blue;
  dmem_if bus ();

  dmem_responder #(
    .DMEM_WORDS(WORDS),
    .DMEM_BASE (BASE),
    .CLK_HZ    (CLK_HZ),
    .INIT_FILE ("")
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus),
    .led  (led),
    .red  (red),
    .green(green),
    .blue (blue)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference state: memory as individual bytes, duty bytes, and cycles since reset.
  logic [7:0]  ramModel [int unsigned];
  logic [7:0]  dutyModel [4];
  longint      tickCount;
  logic [31:0] expDout;
  bit          expDoutKnown;
  bit          expMis;
  bit          modelLive = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic bit loadLegal(input logic [2:0] f3);
    return f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
  endfunction

  function automatic bit storeLegal(input logic [2:0] f3);
    return f3 inside {3'b000, 3'b001, 3'b010};
  endfunction

  function automatic bit misRule(input bit wr, input logic [2:0] f3, input logic [31:0] a);
    bit legal;
    legal = wr ? storeLegal(f3) : loadLegal(f3);
    return legal && ((f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a[1:0] != 2'b00));
  endfunction

  function automatic bit inRamRange(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'(4 * WORDS));
  endfunction

  function automatic logic [7:0] modelByte(input logic [31:0] a, output bit known);
    logic [31:0] micros, millis, w;
    known  = 1'b1;
    micros = 32'(tickCount / TICKS_PER_US);
    millis = 32'(tickCount / TICKS_PER_US / 1000);
    w      = 32'h0;
    if (inRamRange(a)) begin
      if (ramModel.exists(int'(a))) return ramModel[int'(a)];
      known = 1'b0;
      return 8'h00;
    end
    if (a[31:2] == LEDCTL[31:2]) return dutyModel[a[1:0]];
    if (a[31:2] == MILLIS[31:2]) w = millis;
    if (a[31:2] == MICROS[31:2]) w = micros;
    return 8'(w >> (8 * a[1:0]));
  endfunction

  function automatic logic [31:0] modelLoad(input logic [2:0] f3, input logic [31:0] a, output bit known);
    logic [31:0] v;
    bit          k;
    int          size;
    known = 1'b1;
    if (!loadLegal(f3) || misRule(1'b0, f3, a)) return 32'h0;
    size = 1 << f3[1:0];
    v    = 32'h0;
    for (int i = 0; i < size; i++) begin
      v = v | (32'(modelByte(a + 32'(i), k)) << (8 * i));
      if (!k) known = 1'b0;
    end
    if (!f3[2] && size == 1) v = {{24{v[7]}}, v[7:0]};
    if (!f3[2] && size == 2) v = {{16{v[15]}}, v[15:0]};
    return v;
  endfunction

  always @(posedge clk) begin : refModel
    logic [31:0] a, d;
    logic [2:0]  f3;
    logic [31:0] v;
    bit          k, mis;
    a  = bus.dmem_address;
    d  = bus.dmem_data_in;
    f3 = bus.funct3;
    if (reset) begin
      tickCount    = 0;
      for (int i = 0; i < 4; i++) dutyModel[i] = 8'h00;
      expDout      = 32'h0;
      expDoutKnown = 1'b1;
      expMis       = 1'b0;
    end else begin
      mis = misRule(bus.dmem_wren, f3, a);
      if (!bus.dmem_wren) begin
        v            = modelLoad(f3, a, k);
        expDout      = v;
        expDoutKnown = k;
      end else if (storeLegal(f3) && !mis) begin
        for (int i = 0; i < (1 << f3[1:0]); i++) begin
          if (inRamRange(a + 32'(i)))               ramModel[int'(a + 32'(i))] = 8'(d >> (8 * i));
          else if ((a + 32'(i)) >= LEDCTL)         dutyModel[a[1:0] + 2'(i)] = 8'(d >> (8 * i));
        end
      end
      expMis    = mis;
      tickCount = tickCount + 1;
    end
    modelLive = 1'b1;
  end

  always @(negedge clk) begin : compare
    int pwm;
    if (modelLive) begin
      pwm = int'(tickCount % 256);
      if (expDoutKnown) checkOutput("dmem_data_out", bus.dmem_data_out, expDout);
      checkOutput("misaligned", 32'(bus.misaligned), 32'(expMis));
      checkOutput("led",   32'(led),   32'(pwm < int'(dutyModel[0])));
      checkOutput("red",   32'(red),   32'(pwm < int'(dutyModel[1])));
      checkOutput("green", 32'(green), 32'(pwm < int'(dutyModel[2])));
      checkOutput("blue",  32'(blue),  32'(pwm < int'(dutyModel[3])));
    end
  end

  // Drives one access at a falling edge and returns on the next falling edge.
  task automatic applyStimulus(input bit rst, input bit wr, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] data);
    reset            = rst;
    bus.dmem_wren    = wr;
    bus.funct3       = f3;
    bus.dmem_address = addr;
    bus.dmem_data_in = data;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
  endtask

  function automatic logic [31:0] randAddr();
    logic [31:0] r;
    r = 32'($urandom_range(0, 3));
    case ($urandom_range(0, 7))
      0, 1, 2: return BASE + 32'($urandom_range(0, 255));
      3:       return LEDCTL + r;
      4:       return ($urandom_range(0, 1) == 0) ? MILLIS + r : MICROS + r;
      5:       return BASE + 32'(4 * WORDS - 4) + r;
      6:       return ($urandom_range(0, 1) == 0) ? BASE - 32'd4 + r : BASE + 32'(4 * WORDS) + r;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    int cntLed, cntRed, cntGreen, cntBlue;
    bus.funct3 = 3'b010; bus.dmem_wren = 1'b0; bus.dmem_address = 32'h0; bus.dmem_data_in = 32'h0;
    reset = 1'b1;
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h0, 32'h0);
    checkOutput("reset data_out", bus.dmem_data_out, 32'h0);
    checkOutput("reset misaligned", 32'(bus.misaligned), 32'h0);
    checkOutput("reset pwm outputs", {28'h0, led, red, green, blue}, 32'h0);

    for (int i = 0; i < 64; i++) applyStimulus(1'b0, 1'b1, 3'b010, BASE + 32'(4 * i), $urandom());
    applyStimulus(1'b0, 1'b1, 3'b010, BASE + 32'(4 * WORDS - 4), $urandom());

    applyStimulus(1'b0, 1'b1, 3'b010, BASE, 32'hDEAD_BEEF);
    applyStimulus(1'b0, 1'b0, 3'b010, BASE, 32'h0);
    checkOutput("lw deadbeef", bus.dmem_data_out, 32'hDEAD_BEEF);
    applyStimulus(1'b0, 1'b0, 3'b000, BASE, 32'h0);
    checkOutput("lb +0", bus.dmem_data_out, 32'hFFFF_FFEF);
    applyStimulus(1'b0, 1'b0, 3'b100, BASE + 32'd3, 32'h0);
    checkOutput("lbu +3", bus.dmem_data_out, 32'h0000_00DE);
    applyStimulus(1'b0, 1'b0, 3'b101, BASE + 32'd2, 32'h0);
    checkOutput("lhu +2", bus.dmem_data_out, 32'h0000_DEAD);

    applyStimulus(1'b0, 1'b1, 3'b010, BASE, 32'h1122_3344);
    applyStimulus(1'b0, 1'b1, 3'b000, BASE + 32'd1, 32'hFFFF_FF5A);
    applyStimulus(1'b0, 1'b0, 3'b010, BASE, 32'h0);
    checkOutput("sb lane1", bus.dmem_data_out, 32'h1122_5A44);

    applyStimulus(1'b0, 1'b1, 3'b001, BASE + 32'd1, 32'h0000_FFFF);
    checkOutput("sh misaligned pulse", 32'(bus.misaligned), 32'h1);
    applyStimulus(1'b0, 1'b0, 3'b010, BASE, 32'h0);
    checkOutput("misaligned one cycle", 32'(bus.misaligned), 32'h0);
    checkOutput("sh suppressed", bus.dmem_data_out, 32'h1122_5A44);
    applyStimulus(1'b0, 1'b0, 3'b010, BASE + 32'd2, 32'h0);
    checkOutput("lw misaligned pulse", 32'(bus.misaligned), 32'h1);
    checkOutput("lw misaligned data", bus.dmem_data_out, 32'h0);

    applyStimulus(1'b0, 1'b1, 3'b000, 32'hFFFF_FFFD, 32'h0000_0080);
    cntLed = 0; cntRed = 0; cntGreen = 0; cntBlue = 0;
    for (int i = 0; i < 256; i++) begin
      idle(1);
      cntLed += int'(led); cntRed += int'(red); cntGreen += int'(green); cntBlue += int'(blue);
    end
    checkOutput("red duty 0x80", 32'(cntRed), 32'd128);
    checkOutput("led/green/blue off", 32'(cntLed + cntGreen + cntBlue), 32'd0);
    applyStimulus(1'b0, 1'b1, 3'b000, LEDCTL, 32'h0000_00FF);
    cntLed = 0;
    for (int i = 0; i < 256; i++) begin
      idle(1);
      cntLed += int'(led);
    end
    checkOutput("led duty 0xff", 32'(cntLed), 32'd255);
    applyStimulus(1'b0, 1'b1, 3'b010, LEDCTL, 32'h0);
    cntLed = 0;
    for (int i = 0; i < 256; i++) begin
      idle(1);
      cntLed += int'(led) + int'(red) + int'(green) + int'(blue);
    end
    checkOutput("ledctl cleared", 32'(cntLed), 32'd0);

    applyStimulus(1'b1, 1'b0, 3'b010, 32'h0, 32'h0);
    idle(4000);
    applyStimulus(1'b0, 1'b0, 3'b010, MICROS, 32'h0);
    checkOutput("micros after 4000", bus.dmem_data_out, 32'd1000);
    applyStimulus(1'b0, 1'b0, 3'b010, MILLIS, 32'h0);
    checkOutput("millis after 4001", bus.dmem_data_out, 32'd1);
    applyStimulus(1'b0, 1'b1, 3'b010, MILLIS, 32'h1234_5678);
    applyStimulus(1'b0, 1'b0, 3'b010, MILLIS, 32'h0);
    checkOutput("millis write ignored", bus.dmem_data_out, 32'd1);

    applyStimulus(1'b0, 1'b1, 3'b010, BASE + 32'd16, 32'h0BAD_F00D);
    applyStimulus(1'b0, 1'b0, 3'b010, BASE + 32'd16, 32'h0);
    applyStimulus(1'b1, 1'b1, 3'b010, BASE + 32'd16, 32'hFFFF_FFFF);
    checkOutput("reset clears data_out", bus.dmem_data_out, 32'h0);
    applyStimulus(1'b0, 1'b0, 3'b010, BASE + 32'd16, 32'h0);
    checkOutput("store during reset dropped", bus.dmem_data_out, 32'h0BAD_F00D);

    for (int i = 0; i < 2000; i++) begin
      applyStimulus($urandom_range(0, 49) == 0, $urandom_range(0, 2) == 0,
                    3'($urandom_range(0, 7)), randAddr(), $urandom());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
